// File: rtl/two_digit_down_timer.sv
// Two-digit BCD countdown timer with prescaled tick, pause/resume and
// optional auto-reload. Shares the load/count digit interface of the
// two-digit up counter so the same display consumers can be driven.
module two_digit_down_timer #(
   parameter int unsigned TICK_DIV    = 1,
   parameter bit          AUTO_RELOAD = 1'b0
) (
   input  logic       CLK,
   input  logic       Clear,
   input  logic [3:0] Ain,
   input  logic [3:0] Bin,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] AO,
   output logic [3:0] BO,
   output logic       borrowOut,
   output logic       zero,
   output logic       done,
   output logic       busy
);

   localparam int unsigned   PW        = $clog2(TICK_DIV) + 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED,
      DONE
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [3:0]    rel_a;
   logic [3:0]    rel_b;

   logic          tick;
   logic [3:0]    dec_a;
   logic [3:0]    dec_b;
   logic          wrap;
   logic          expire;
   logic          reload_nonzero;

   // Out-of-range BCD load digits saturate to 9.
   function automatic logic [3:0] sanitize(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // Next digit values for a decrement; a ones wrap borrows from the tens.
   always_comb begin
      dec_a = AO - 4'd1;
      dec_b = BO;
      wrap  = 1'b0;
      if (AO == 4'd0) begin
         dec_a = 4'd9;
         dec_b = BO - 4'd1;
         wrap  = 1'b1;
      end
   end

   assign tick           = (presc == TICK_LAST);
   assign expire         = (dec_a == 4'd0) && (dec_b == 4'd0);
   assign reload_nonzero = (rel_a != 4'd0) || (rel_b != 4'd0);

   assign zero = (AO == 4'd0) && (BO == 4'd0);
   assign busy = (state == RUN) || (state == PAUSED);

   // Control FSM, digits, prescaler and registered pulse outputs.
   always_ff @(posedge CLK) begin
      if (Clear) begin
         state     <= IDLE;
         AO        <= '0;
         BO        <= '0;
         rel_a     <= '0;
         rel_b     <= '0;
         presc     <= '0;
         borrowOut <= 1'b0;
         done      <= 1'b0;
      end else if (load) begin
         state     <= IDLE;
         AO        <= sanitize(Ain);
         BO        <= sanitize(Bin);
         rel_a     <= sanitize(Ain);
         rel_b     <= sanitize(Bin);
         presc     <= '0;
         borrowOut <= 1'b0;
         done      <= 1'b0;
      end else begin
         borrowOut <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               // RUN is never entered at 00, which keeps BO from underflowing.
               if (start && !zero) begin
                  state <= RUN;
                  presc <= '0;
               end
            end
            PAUSED: begin
               // Resume keeps the prescaler phase reached before the pause.
               if (start) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (pause) begin
                  state <= PAUSED;
               end else if (tick) begin
                  presc     <= '0;
                  AO        <= dec_a;
                  BO        <= dec_b;
                  borrowOut <= wrap;
                  if (expire) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
            end
            DONE: begin
               if (AUTO_RELOAD && reload_nonzero) begin
                  state <= RUN;
                  AO    <= rel_a;
                  BO    <= rel_b;
                  presc <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/two_digit_down_timer.md
Name: two_digit_down_timer

Overview:
Two-digit BCD countdown timer. It is the decrementing counterpart of the team's two-digit up counter and uses the same load/count digit interface. It loads a 00–99 value, counts down to 00 on a prescaled tick, and signals a borrow on each ones-digit wrap and a done pulse at expiry. It supports pause/resume and optional auto-reload, and drives the same display/digit consumers as the up counter.

Parameters:
TICK_DIV, 1, RUN-state clock cycles per decrement (>=1); prescaler width = clog2(TICK_DIV)+1
AUTO_RELOAD, 0, 1 = on expiry reload the last loaded value and keep running; 0 = stop

Ports:
CLK  input  1  single clock, all state updates on rising edge
Clear  input  1  reset, synchronous, active-high
Ain  input  4  ones-digit load value (BCD)
Bin  input  4  tens-digit load value (BCD)
load  input  1  capture Ain/Bin into digits and reload register
start  input  1  begin/resume countdown
pause  input  1  suspend countdown
AO  output  4  ones digit, registered
BO  output  4  tens digit, registered
borrowOut  output  1  registered one-cycle pulse, ones digit wrapped 0->9
zero  output  1  combinational, AO==0 && BO==0
done  output  1  registered, high exactly while in DONE (one cycle)
busy  output  1  combinational, state is RUN or PAUSED

Behaviour:
- Clock/reset: one clock CLK; Clear is synchronous, active-high.
- Reset values: AO=0, BO=0, reload register=00, prescaler=0, borrowOut=0, done=0, state=IDLE. This gives zero=1 and busy=0.
- States: IDLE, RUN, PAUSED, DONE.
- Per-cycle priority: Clear > load > start > pause > tick.
- load, in any state:
  - Each digit is sanitized: a value >9 saturates to 9.
  - AO/BO and the reload register take the sanitized values next cycle.
  - state -> IDLE, prescaler -> 0, borrowOut -> 0, done -> 0.
- start:
  - IDLE with nonzero digits -> RUN, prescaler 0.
  - IDLE with 00 -> ignored; no done pulse.
  - PAUSED -> RUN, prescaler retained.
  - RUN and DONE -> ignored.
- pause:
  - RUN -> PAUSED; digits and prescaler held.
  - Ignored in all other states.
  - start and pause together in PAUSED: start wins.
- Tick: in RUN, tick = (prescaler == TICK_DIV-1). Prescaler wraps to 0 on tick, otherwise increments. With TICK_DIV=1, every RUN cycle is a tick.
- Decrement on tick:
  - AO>0: AO-1.
  - AO==0: AO=9, BO-1, borrowOut=1 on the same cycle the new value appears.
  - 01->00 produces no borrow.
- Expiry:
  - A tick that produces 00 moves the state to DONE; done=1 in the same cycle the digits show 00.
  - Cycle after DONE, AUTO_RELOAD=0: IDLE, done=0, digits stay 00.
  - Cycle after DONE, AUTO_RELOAD=1 and reload!=00: digits = reload value, RUN, prescaler 0.
- Clear mid-run: next cycle is the full reset state; no done and no borrow pulse.
- Widths: digits are always valid BCD 0–9. BO never underflows, because RUN is never entered or held at 00.

Test Plan:
1. Reset: Clear=1 for 2 cycles with load=1 and start=1 asserted -> AO=0, BO=0, zero=1, busy=0, done=0, borrowOut=0.
2. Countdown, TICK_DIV=1:
   - load Ain=3, Bin=1 (13), then start at cycle k.
   - Cycle k+1: RUN, 13. Cycle k+2: 12.
   - 10->09 cycle has borrowOut=1 for exactly one cycle.
   - Cycle k+14: 00, done=1. Cycle k+15: IDLE, done=0.
3. Sanitize: load Ain=4'hC, Bin=4'hF -> AO=9, BO=9.
4. Pause/resume:
   - Pause at 07 for 5 cycles -> holds 07, busy=1, no borrow.
   - start -> next cycle RUN, following cycle 06.
   - With TICK_DIV=4, prescaler phase is preserved across the pause.
5. AUTO_RELOAD=1: load 02, start -> 02,01,00(done=1),02,01,00(done=1)... continuing; load 00 mid-run -> IDLE, stops.
6. Boundaries:
   - Clear during RUN at 05 -> next cycle 00, IDLE, done=0.
   - load and start together -> load wins, IDLE.
   - start with value 00 -> stays IDLE, no done.
